// File: rtl/image_sram_loader.sv
// image_sram_loader
//   Host-side writer for the input SRAM of the binary 3x3 XNOR-conv engine.
//   For each image it writes a header word (the dimension N) and then N row
//   words. Each row word packs the serial pixel bits of one row, with column c
//   in bit c. After the last image it writes the end-of-list word, pulses
//   dut_run, and follows dut_busy until the engine has finished.
//
// Ports
//   clk, reset_b                 clock / asynchronous active-low reset
//   img_start, img_dim[4:0]      request a new image of dimension N (10/12/16)
//   pix_valid, pix_data          serial pixel bits, row-major, column 0 first
//   pix_ready                    high while pixel bits are being accepted
//   load_done                    no more images: write terminator, run engine
//   dut_busy / dut_run           engine handshake (busy flag / start pulse)
//   loader_sram_write_*          input-SRAM write port (address/data/enable)
//   loader_busy                  high whenever the loader is not idle
//   loader_err                   one-cycle pulse: image start rejected
//   loader_done                  one-cycle pulse: engine run finished
module image_sram_loader #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] TERM_WORD = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              img_start,
  input  logic [4:0]        img_dim,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  input  logic              load_done,
  input  logic              dut_busy,
  output logic              dut_run,
  output logic [ADDR_W-1:0] loader_sram_write_address,
  output logic [DATA_W-1:0] loader_sram_write_data,
  output logic              loader_sram_write_enable,
  output logic              loader_busy,
  output logic              loader_err,
  output logic              loader_done
);

  localparam int CW = $clog2(DATA_W);
  // Total number of SRAM words, one bit wider than the address.
  localparam logic [ADDR_W:0] MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PACK,
    S_TERM,
    S_RUN,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [4:0]          col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [4:0]          dim_q, dim_d;
  logic [DATA_W-1:0]   word_q, word_d;

  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                run_q, run_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  function automatic logic [DATA_W-1:0] insert_bit(input logic [DATA_W-1:0] word,
                                                    input logic [CW-1:0]     pos,
                                                    input logic              b);
    logic [DATA_W-1:0] w;
    w      = word;
    w[pos] = b;
    return w;
  endfunction

  function automatic logic dim_legal(input logic [4:0] d);
    return (d == 5'd10) || (d == 5'd12) || (d == 5'd16);
  endfunction

  logic [ADDR_W:0]   img_end;
  logic              img_fits;
  logic              accept;
  logic              last_col;
  logic              last_row;
  logic [DATA_W-1:0] word_next;

  always_comb begin
    // Header, N rows and the terminator must all fit below the top of SRAM.
    img_end   = {1'b0, addr_q} + {{(ADDR_W-4){1'b0}}, img_dim} + (ADDR_W+1)'(2);
    img_fits  = (img_end <= MEM_WORDS);
    accept    = ready_q && pix_valid;
    last_col  = (col_q == dim_q - 5'd1);
    last_row  = (row_q == dim_q - 5'd1);
    word_next = insert_bit(word_q, col_q[CW-1:0], pix_data);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    dim_d   = dim_q;
    word_d  = word_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    run_d   = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (img_start) begin
          if (dim_legal(img_dim) && img_fits) begin
            we_d    = 1'b1;
            wa_d    = addr_q;
            wd_d    = {{(DATA_W-5){1'b0}}, img_dim};
            addr_d  = addr_q + 1'b1;
            dim_d   = img_dim;
            col_d   = '0;
            row_d   = '0;
            word_d  = '0;
            state_d = S_PACK;
          end else begin
            err_d = 1'b1;
          end
        end else if (load_done) begin
          // Address is not advanced: it is cleared once the engine finishes.
          we_d    = 1'b1;
          wa_d    = addr_q;
          wd_d    = TERM_WORD;
          state_d = S_TERM;
        end
      end

      S_PACK: begin
        if (accept) begin
          if (last_col) begin
            // Row complete: write it with the final bit merged in, and start
            // the next row from a clear word so bits [15:N] stay zero.
            we_d   = 1'b1;
            wa_d   = addr_q;
            wd_d   = word_next;
            addr_d = addr_q + 1'b1;
            word_d = '0;
            col_d  = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + 5'd1;
            end
          end else begin
            word_d = word_next;
            col_d  = col_q + 5'd1;
          end
        end
      end

      S_TERM: begin
        run_d   = 1'b1;
        state_d = S_RUN;
      end

      // dut_run is high during S_RUN; the engine cannot answer before then.
      S_RUN: state_d = S_WAIT_HI;

      S_WAIT_HI: begin
        if (dut_busy) state_d = S_WAIT_LO;
      end

      S_WAIT_LO: begin
        if (!dut_busy) begin
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_PACK);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output register stage
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dim_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dim_q   <= dim_d;
      word_q  <= word_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      run_q   <= run_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign pix_ready                 = ready_q;
  assign dut_run                   = run_q;
  assign loader_sram_write_address = wa_q;
  assign loader_sram_write_data    = wd_q;
  assign loader_sram_write_enable  = we_q;
  assign loader_busy               = busy_q;
  assign loader_err                = err_q;
  assign loader_done               = done_q;

endmodule

// File: tb/tb_image_sram_loader.sv
`timescale 1ns/1ps
module tb_image_sram_loader;

  localparam int KW = 0;  // SRAM write
  localparam int KE = 1;  // loader_err pulse
  localparam int KR = 2;  // dut_run pulse
  localparam int KD = 3;  // loader_done pulse

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        img_start = 1'b0;
  logic [4:0]  img_dim = '0;
  logic        pix_valid = 1'b0;
  logic        pix_data = 1'b0;
  logic        load_done = 1'b0;
  logic        dut_busy = 1'b0;
  logic        pix_ready;
  logic        dut_run;
  logic [11:0] loader_sram_write_address;
  logic [15:0] loader_sram_write_data;
  logic        loader_sram_write_enable;
  logic        loader_busy;
  logic        loader_err;
  logic        loader_done;

  image_sram_loader dut (
    .clk                       (clk),
    .reset_b                   (reset_b),
    .img_start                 (img_start),
    .img_dim                   (img_dim),
    .pix_valid                 (pix_valid),
    .pix_data                  (pix_data),
    .pix_ready                 (pix_ready),
    .load_done                 (load_done),
    .dut_busy                  (dut_busy),
    .dut_run                   (dut_run),
    .loader_sram_write_address (loader_sram_write_address),
    .loader_sram_write_data    (loader_sram_write_data),
    .loader_sram_write_enable  (loader_sram_write_enable),
    .loader_busy               (loader_busy),
    .loader_err                (loader_err),
    .loader_done               (loader_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  model_addr = 0;
  int  run_seen = 0;
  int  done_seen = 0;
  bit  busy_dropped = 1'b0;

  function automatic string kname(input int k);
    case (k)
      KW:      return "write";
      KE:      return "err";
      KR:      return "run";
      default: return "done";
    endcase
  endfunction

  function automatic void push(input int k, input int a, input int d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(input int k, input int a, input int d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s got addr=%0d data=%h required no event", kname(k), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        failures++;
        $display("FAIL event_%s got %s addr=%0d data=%h required %s addr=%0d data=%h",
                 kname(e.kind), kname(k), a, d, kname(e.kind), e.addr, e.data);
      end
    end
  endtask

  // Monitor: every output event is matched against the expectation queue.
  always @(negedge clk) begin
    if (reset_b) begin
      if (loader_sram_write_enable)
        pop_cmp(KW, int'(loader_sram_write_address), int'(loader_sram_write_data));
      if (loader_err) pop_cmp(KE, 0, 0);
      if (dut_run) begin
        run_seen++;
        pop_cmp(KR, 0, 0);
      end
      if (loader_done) begin
        done_seen++;
        pop_cmp(KD, 0, int'(busy_dropped));
      end
    end
  end

  task automatic check_outputs_zero(input string nm);
    logic [33:0] o;
    o = {loader_sram_write_enable, loader_sram_write_address, loader_sram_write_data,
         dut_run, loader_busy, loader_err, loader_done, pix_ready};
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL %s outputs=%h required 0", nm, o);
    end
  endtask

  task automatic apply_reset(input string nm);
    #2;
    reset_b   = 1'b0;
    pix_valid = 1'b0;
    img_start = 1'b0;
    load_done = 1'b0;
    dut_busy  = 1'b0;
    #1;
    check_outputs_zero(nm);
    exp_q.delete();
    model_addr = 0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (loader_busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (loader_busy) begin
      failures++;
      $display("FAIL idle_timeout loader_busy=%0b required 0", loader_busy);
    end
  endtask

  task automatic send_pixels(input logic [255:0] bits, input int n, input bit rnd, input int stop_at);
    int idx;
    int guard;
    logic v;
    logic r;
    idx   = 0;
    guard = 0;
    while (idx < stop_at && guard < 4 * n + 50) begin
      @(negedge clk);
      v         = rnd ? 1'($urandom % 2) : 1'b1;
      pix_valid = v;
      pix_data  = v ? bits[idx] : 1'($urandom % 2);
      img_start = rnd ? ($urandom % 8 == 0) : 1'b0;
      load_done = rnd ? ($urandom % 8 == 0) : 1'b0;
      img_dim   = 5'($urandom);
      r         = pix_ready;
      @(posedge clk);
      if (r && v) idx++;
      guard++;
    end
    checks++;
    if (idx < stop_at) begin
      failures++;
      $display("FAIL pixel_timeout accepted=%0d required %0d", idx, stop_at);
    end
  endtask

  task automatic do_image(input int n, input int pat, input bit rnd, input int reset_after);
    logic [255:0] bits;
    int w;
    bit legal;
    bits  = '0;
    legal = (n == 10 || n == 12 || n == 16) && (model_addr + n + 2 <= 4096);
    @(negedge clk);
    img_start = 1'b1;
    img_dim   = 5'(n);
    load_done = 1'($urandom % 2);
    if (legal) begin
      push(KW, model_addr, n);
      model_addr++;
      for (int r = 0; r < n; r++) begin
        w = 0;
        for (int c = 0; c < n; c++) begin
          case (pat)
            1:       bits[r*n+c] = 1'b1;
            2:       bits[r*n+c] = (c % 2 == 0);
            default: bits[r*n+c] = 1'($urandom % 2);
          endcase
          if (bits[r*n+c]) w += (1 << c);
        end
        push(KW, model_addr, w);
        model_addr++;
      end
    end else begin
      push(KE, 0, 0);
    end
    @(negedge clk);
    img_start = 1'b0;
    load_done = 1'b0;
    if (legal) begin
      send_pixels(bits, n * n, rnd, (reset_after > 0) ? reset_after : n * n);
      if (reset_after > 0) begin
        apply_reset("reset_in_pack");
        return;
      end
      @(negedge clk);
      pix_valid = 1'b0;
      img_start = 1'b0;
      load_done = 1'b0;
    end
    wait_idle();
  endtask

  task automatic do_term(input bit reset_in_wait);
    int r0;
    int d0;
    int g;
    @(negedge clk);
    load_done = 1'b1;
    push(KW, model_addr, 16'h00FF);
    push(KR, 0, 0);
    push(KD, 0, 1);
    busy_dropped = 1'b0;
    r0 = run_seen;
    d0 = done_seen;
    @(negedge clk);
    load_done = 1'b0;
    g = 0;
    #1;
    while (run_seen == r0 && g < 12) begin
      @(negedge clk);
      #1;
      g++;
    end
    checks++;
    if (run_seen == r0) begin
      failures++;
      $display("FAIL run_timeout run_pulses=%0d required %0d", run_seen - r0, 1);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    dut_busy = 1'b1;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    if (reset_in_wait) begin
      apply_reset("reset_in_wait_lo");
      return;
    end
    dut_busy     = 1'b0;
    busy_dropped = 1'b1;
    g = 0;
    #1;
    while (done_seen == d0 && g < 6) begin
      @(negedge clk);
      #1;
      g++;
    end
    checks++;
    if (done_seen == d0) begin
      failures++;
      $display("FAIL done_timeout done_pulses=%0d required %0d", done_seen - d0, 1);
    end
    model_addr = 0;
    wait_idle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached, pending=%0d required 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int illegal[5];
    int dims[3];
    illegal = '{11, 0, 31, 15, 20};
    dims    = '{10, 12, 16};

    #12;
    check_outputs_zero("reset_state");
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);

    // Single N=10 image, valid every cycle, then terminate and run.
    do_image(10, 0, 1'b0, 0);
    do_term(1'b0);

    // All-ones N=16 row words and alternating N=12 row words.
    do_image(16, 1, 1'b1, 0);
    do_image(12, 2, 1'b1, 0);
    do_term(1'b0);

    // Illegal dimensions are rejected without writes; next image starts at 0.
    do_image(11, 0, 1'b0, 0);
    do_image(10, 0, 1'b1, 0);
    for (int i = 1; i < 5; i++) do_image(illegal[i], 0, 1'b0, 0);
    do_term(1'b0);

    // Terminator with no images loaded.
    do_term(1'b0);

    // Random images with gappy pix_valid and stray control inputs.
    for (int i = 0; i < 6; i++) begin
      do_image(dims[$urandom_range(0, 2)], 0, 1'b1, 0);
      if ($urandom % 3 == 0) do_image(illegal[$urandom_range(0, 4)], 0, 1'b0, 0);
    end
    do_term(1'b0);

    // Reset during pixel packing, then during the wait for busy to fall.
    do_image(10, 0, 1'b1, 37);
    do_image(12, 0, 1'b1, 0);
    do_term(1'b1);
    do_image(10, 0, 1'b0, 0);
    do_term(1'b0);

    // Fill SRAM to address 4080, then a start that would not fit.
    for (int i = 0; i < 365; i++) do_image(10, 0, 1'b0, 0);
    for (int i = 0; i < 5; i++) do_image(12, 0, 1'b0, 0);
    checks++;
    if (model_addr != 4080) begin
      failures++;
      $display("FAIL fill_addr model=%0d required 4080", model_addr);
    end
    do_image(16, 0, 1'b0, 0);
    do_term(1'b0);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events count=%0d required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
